// File: rtl/valid_ready_width_upsizer.sv
// Packs RATIO narrow valid-ready beats into one wide word with a per-lane mask.
// A word closes early on input_last; unused upper lanes are zero with mask bits low.
module valid_ready_width_upsizer #(
  parameter int WIDTH = 8,
  parameter int RATIO = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         input_data,
  input  logic                     input_last,
  input  logic                     input_valid,
  output logic                     input_ready,
  output logic [WIDTH*RATIO-1:0]   output_data,
  output logic [RATIO-1:0]         output_mask,
  output logic                     output_last,
  output logic                     output_valid,
  input  logic                     output_ready
);

  localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int ACC_W = WIDTH * (RATIO - 1);
  localparam int OUT_W = WIDTH * RATIO;
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(RATIO - 1);

  logic [IDX_W-1:0] idx_q, idx_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [RATIO-2:0] acc_mask_q, acc_mask_d;
  logic [OUT_W-1:0] data_q, data_d;
  logic [RATIO-1:0] mask_q, mask_d;
  logic             last_q, last_d;
  logic             valid_q, valid_d;

  logic             beat_fire;
  logic             complete;
  logic [OUT_W-1:0] word_c;
  logic [RATIO-1:0] word_mask_c;

  // Ready depends only on the output handshake, so upstream never sees a loop.
  assign input_ready = ~valid_q | output_ready;

  assign output_data  = data_q;
  assign output_mask  = mask_q;
  assign output_last  = last_q;
  assign output_valid = valid_q;

  always_comb begin
    beat_fire   = input_valid & input_ready;
    complete    = beat_fire & (input_last | (idx_q == IDX_MAX));

    word_c      = '0;
    word_mask_c = '0;
    for (int l = 0; l < RATIO - 1; l++) begin
      word_c[l*WIDTH +: WIDTH] = acc_q[l*WIDTH +: WIDTH];
      word_mask_c[l]           = acc_mask_q[l];
    end
    for (int l = 0; l < RATIO; l++) begin
      if (idx_q == IDX_W'(l)) begin
        word_c[l*WIDTH +: WIDTH] = input_data;
        word_mask_c[l]           = 1'b1;
      end
    end

    idx_d      = idx_q;
    acc_d      = acc_q;
    acc_mask_d = acc_mask_q;
    data_d     = data_q;
    mask_d     = mask_q;
    last_d     = last_q;
    valid_d    = valid_q;

    if (complete) begin
      // A drain in the same cycle is covered: the new word simply replaces it.
      idx_d      = '0;
      acc_d      = '0;
      acc_mask_d = '0;
      data_d     = word_c;
      mask_d     = word_mask_c;
      last_d     = input_last;
      valid_d    = 1'b1;
    end else begin
      if (beat_fire) begin
        idx_d = idx_q + IDX_W'(1);
        for (int l = 0; l < RATIO - 1; l++) begin
          if (idx_q == IDX_W'(l)) begin
            acc_d[l*WIDTH +: WIDTH] = input_data;
            acc_mask_d[l]           = 1'b1;
          end
        end
      end
      if (output_ready) begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idx_q      <= '0;
      acc_q      <= '0;
      acc_mask_q <= '0;
      data_q     <= '0;
      mask_q     <= '0;
      last_q     <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      idx_q      <= idx_d;
      acc_q      <= acc_d;
      acc_mask_q <= acc_mask_d;
      data_q     <= data_d;
      mask_q     <= mask_d;
      last_q     <= last_d;
      valid_q    <= valid_d;
    end
  end

endmodule

// File: tb/tb_valid_ready_width_upsizer.sv
// Bench for valid_ready_width_upsizer (WIDTH=8, RATIO=4): directed cases plus
// randomized handshakes against a queue-based word model.
module tb_valid_ready_width_upsizer;

  localparam int WIDTH = 8;
  localparam int RATIO = 4;
  localparam int DW    = WIDTH * RATIO;

  typedef struct {
    logic [DW-1:0]    data;
    logic [RATIO-1:0] mask;
    logic             last;
  } word_t;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic [WIDTH-1:0] input_data;
  logic             input_last;
  logic             input_valid;
  logic             input_ready;
  logic [DW-1:0]    output_data;
  logic [RATIO-1:0] output_mask;
  logic             output_last;
  logic             output_valid;
  logic             output_ready;

  int checks   = 0;
  int failures = 0;
  int beats    = 0;

  word_t            exp_q[$];
  logic [WIDTH-1:0] cur_q[$];
  word_t            mdl_last;

  valid_ready_width_upsizer #(.WIDTH(WIDTH), .RATIO(RATIO)) dut (
    .clock        (clock),
    .reset        (reset),
    .input_data   (input_data),
    .input_last   (input_last),
    .input_valid  (input_valid),
    .input_ready  (input_ready),
    .output_data  (output_data),
    .output_mask  (output_mask),
    .output_last  (output_last),
    .output_valid (output_valid),
    .output_ready (output_ready)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: collect beats of the open word; a word closes at RATIO beats or on last.
  task automatic model_beat(input logic [WIDTH-1:0] d, input logic l);
    word_t w;
    cur_q.push_back(d);
    if (cur_q.size() == RATIO || l) begin
      w.data = '0;
      w.mask = '0;
      for (int k = 0; k < cur_q.size(); k++) begin
        w.data = w.data | (DW'(cur_q[k]) << (k * WIDTH));
        w.mask[k] = 1'b1;
      end
      w.last = l;
      exp_q.push_back(w);
      mdl_last = w;
      cur_q.delete();
    end
  endtask

  always @(negedge clock) begin
    if (reset) begin
      chk("rst_valid", 64'(output_valid), 64'(0));
      chk("rst_data",  64'(output_data),  64'(0));
      chk("rst_mask",  64'(output_mask),  64'(0));
      chk("rst_last",  64'(output_last),  64'(0));
      chk("rst_ready", 64'(input_ready),  64'(1));
      exp_q.delete();
      cur_q.delete();
    end else begin
      chk("ready_rule", 64'(input_ready), 64'(!output_valid || output_ready));
      chk("valid_vs_model", 64'(output_valid), 64'(exp_q.size() != 0));
      if (output_valid && exp_q.size() != 0) begin
        chk("word_data", 64'(output_data), 64'(exp_q[0].data));
        chk("word_mask", 64'(output_mask), 64'(exp_q[0].mask));
        chk("word_last", 64'(output_last), 64'(exp_q[0].last));
        chk("mask_nonzero", 64'(output_mask != 0), 64'(1));
        if (output_ready) void'(exp_q.pop_front());
      end
      if (input_valid && input_ready) begin
        beats++;
        model_beat(input_data, input_last);
      end
    end
  end

  task automatic drive(input logic [WIDTH-1:0] d, input logic l, input logic v);
    input_data  = d;
    input_last  = l;
    input_valid = v;
    @(posedge clock);
    #1;
  endtask

  task automatic chk_word(input string name, input logic [DW-1:0] d, input logic [RATIO-1:0] m, input logic l);
    chk({name, "_valid"}, 64'(output_valid), 64'(1));
    chk({name, "_data"},  64'(output_data),  64'(d));
    chk({name, "_mask"},  64'(output_mask),  64'(m));
    chk({name, "_last"},  64'(output_last),  64'(l));
  endtask

  initial begin
    int start;
    int cyc;
    input_data   = '0;
    input_last   = 1'b0;
    input_valid  = 1'b0;
    output_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("init_valid", 64'(output_valid), 64'(0));
    chk("init_data",  64'(output_data),  64'(0));
    chk("init_ready", 64'(input_ready),  64'(1));
    reset = 1'b0;
    drive(8'h00, 1'b0, 1'b0);

    // Full word, no last
    drive(8'h11, 1'b0, 1'b1);
    drive(8'h22, 1'b0, 1'b1);
    drive(8'h33, 1'b0, 1'b1);
    drive(8'h44, 1'b0, 1'b1);
    chk_word("w034", 32'h44332211, 4'hF, 1'b0);
    chk("mdl_034", 64'(mdl_last.data), 64'(32'h44332211));
    drive(8'h00, 1'b0, 1'b0);
    chk("w034_one_cycle", 64'(output_valid), 64'(0));

    // Short word closed by last, then single-lane word back-to-back
    drive(8'hAA, 1'b0, 1'b1);
    drive(8'hBB, 1'b1, 1'b1);
    chk_word("w035", 32'h0000BBAA, 4'h3, 1'b1);
    chk("mdl_035", 64'(mdl_last.mask), 64'(4'h3));
    drive(8'hCC, 1'b1, 1'b1);
    chk_word("w027", 32'h000000CC, 4'h1, 1'b1);
    drive(8'h00, 1'b0, 1'b0);

    // Last on the final lane
    drive(8'hD1, 1'b0, 1'b1);
    drive(8'hD2, 1'b0, 1'b1);
    drive(8'hD3, 1'b0, 1'b1);
    drive(8'hD4, 1'b1, 1'b1);
    chk_word("w026", 32'hD4D3D2D1, 4'hF, 1'b1);
    drive(8'h00, 1'b0, 1'b0);

    // Streaming at one beat per cycle
    for (int i = 1; i <= 8; i++) begin
      chk("ready_036", 64'(input_ready), 64'(1));
      drive(8'(i), 1'b0, 1'b1);
      if (i == 4) chk_word("w036a", 32'h04030201, 4'hF, 1'b0);
      if (i == 8) chk_word("w036b", 32'h08070605, 4'hF, 1'b0);
    end
    drive(8'h00, 1'b0, 1'b0);

    // Backpressure: word held, then drained together with a waiting completing beat
    output_ready = 1'b0;
    drive(8'h31, 1'b0, 1'b1);
    drive(8'h32, 1'b0, 1'b1);
    drive(8'h33, 1'b0, 1'b1);
    drive(8'h34, 1'b0, 1'b1);
    input_data  = 8'h99;
    input_last  = 1'b1;
    input_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_ready", 64'(input_ready), 64'(0));
      chk_word("bp_hold", 32'h34333231, 4'hF, 1'b0);
      @(posedge clock);
      #1;
    end
    output_ready = 1'b1;
    @(posedge clock);
    #1;
    chk_word("w037", 32'h00000099, 4'h1, 1'b1);
    drive(8'h00, 1'b0, 1'b0);
    chk("w037_drained", 64'(output_valid), 64'(0));

    // Reset mid-word
    drive(8'h10, 1'b0, 1'b1);
    drive(8'h20, 1'b0, 1'b1);
    input_data = 8'hEE;
    reset = 1'b1;
    #1;
    chk("arst_valid", 64'(output_valid), 64'(0));
    chk("arst_data",  64'(output_data),  64'(0));
    chk("arst_mask",  64'(output_mask),  64'(0));
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    drive(8'h55, 1'b0, 1'b1);
    drive(8'h56, 1'b0, 1'b1);
    drive(8'h57, 1'b0, 1'b1);
    drive(8'h58, 1'b0, 1'b1);
    chk_word("w038", 32'h58575655, 4'hF, 1'b0);
    drive(8'h00, 1'b0, 1'b0);

    // Randomized handshakes
    start = beats;
    cyc   = 0;
    while ((beats - start) < 1000 && cyc < 20000) begin
      input_valid  = ($urandom_range(0, 3) != 0);
      input_data   = 8'($urandom);
      input_last   = ($urandom_range(0, 5) == 0);
      output_ready = ($urandom_range(0, 3) != 0);
      @(posedge clock);
      #1;
      cyc++;
    end
    chk("rand_beats_done", 64'((beats - start) >= 1000), 64'(1));
    input_valid  = 1'b0;
    output_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("drain_empty", 64'(exp_q.size()), 64'(0));
    chk("drain_valid", 64'(output_valid), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/valid_ready_width_upsizer.md
VALID_READY_WIDTH_UPSIZER -- requirements
Module: valid_ready_width_upsizer

Interface
REQ-001 SHALL have parameter WIDTH, default 8: width of one input beat in bits.
REQ-002 SHALL have parameter RATIO, default 4: input beats per output word; legal range 2..16.
REQ-003 SHALL have port clock  input  1  single clock for all logic, rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port input_data  input  WIDTH  narrow beat.
REQ-006 SHALL have port input_last  input  1  beat closes the current word early.
REQ-007 SHALL have port input_valid  input  1  upstream beat present.
REQ-008 SHALL have port input_ready  output  1  block accepts a beat this cycle.
REQ-009 SHALL have port output_data  output  WIDTH*RATIO  packed word; feeds the write side of a valid-ready FIFO.
REQ-010 SHALL have port output_mask  output  RATIO  one bit per lane, set if the lane holds a valid beat.
REQ-011 SHALL have port output_last  output  1  word was closed by input_last.
REQ-012 SHALL have port output_valid  output  1  packed word present.
REQ-013 SHALL have port output_ready  input  1  downstream accepts the word.

Function
REQ-014 SHALL transfer a beat when input_valid and input_ready are both high on a rising clock edge; a word SHALL transfer when output_valid and output_ready are both high.
REQ-015 SHALL keep a lane index counter (0..RATIO-1), width CLOG2(RATIO), plus a partial-word accumulator of RATIO-1 lanes with a mask.
REQ-016 SHALL place the beat accepted at index k in bits [k*WIDTH +: WIDTH] of the word, lane 0 in the LSBs, and SHALL set mask bit k.
REQ-017 SHALL treat an accepted beat as completing when index == RATIO-1 or input_last is high; otherwise SHALL store it in the accumulator and increment the index.
REQ-018 On a completing beat, SHALL load the output register with accumulator lanes plus the new beat, set output_mask accordingly, set output_last = input_last, assert output_valid next cycle, clear the accumulator and mask, and reset the index to 0.
REQ-019 SHALL drive lanes above the last valid lane of a short word to zero, with the corresponding mask bits low.
REQ-020 SHALL drive input_ready = ~output_valid | output_ready, combinational from output_ready only, never from input_valid or input_last.
REQ-021 Latency: completing beat accepted at edge N gives output_valid high after edge N; word visible in cycle N+1.
REQ-022 With output_ready held high, SHALL sustain 1 beat per cycle, i.e. one word per RATIO cycles, with no bubbles.
REQ-023 SHALL hold output_data, output_mask, output_last and output_valid stable while output_valid is high and output_ready is low.
REQ-024 Simultaneous word drain and completing beat in the same cycle: SHALL load the new word, keeping output_valid high with no idle cycle.
REQ-025 Word drain with no completing beat: SHALL clear output_valid on that edge.
REQ-026 input_last on the beat at index RATIO-1 SHALL produce a full mask and output_last = 1.
REQ-027 input_last on index 0 SHALL produce mask = 1 (single lane).
REQ-028 SHALL never emit a word with an all-zero mask.
REQ-029 SHALL hold input_data lanes unmodified; no reordering or byte-swapping.

Reset
REQ-030 While reset is high, SHALL force output_valid = 0, output_last = 0, output_mask = 0, output_data = 0, index = 0, accumulator and its mask = 0, asynchronously and independent of clock.
REQ-031 While reset is high, input_ready SHALL read 1 per REQ-020; beats presented during reset SHALL be discarded.
REQ-032 Reset mid-word SHALL discard the partial accumulator and any pending output word without emitting them.
REQ-033 After reset deassertion, the first accepted beat SHALL land in lane 0.

Verification (WIDTH=8, RATIO=4)
REQ-034 Beats 0x11,0x22,0x33,0x44, no last, output_ready=1 -> one word 0x44332211, mask 0xF, last 0, output_valid for 1 cycle, in the cycle after 0x44 is accepted.
REQ-035 Beats 0xAA,0xBB with last on 0xBB -> word 0x0000BBAA, mask 0x3, last 1; next beat 0xCC lands in lane 0.
REQ-036 Continuous 8 beats 0x01..0x08, output_ready=1 -> words 0x04030201 then 0x08070605, input_ready never low.
REQ-037 output_ready=0 with a word pending -> input_ready=0 and word stable for 5 cycles; raise output_ready with a completing beat waiting -> back-to-back words, no gap.
REQ-038 Reset pulse after 2 beats of a word -> all outputs 0 immediately; next 4 beats 0x55..0x58 -> word 0x58575655, mask 0xF.
REQ-039 Random valid/ready toggling, 1000 beats with random last, checked against a scoreboard model -> no beat lost, duplicated or misplaced, and mask always non-zero.
